// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and defaults for the MAC operand sequencer
package mac_seq_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } mac_seq_state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mac_seq_fifo.sv
// rtl/mac_seq_fifo.sv - synchronous operand-pair FIFO, no fall-through, with flush
module mac_seq_fifo
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  operand_pair_t                din,
  input  logic                         pop,
  output operand_pair_t                dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  operand_pair_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic push_ok;
  logic pop_ok;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - buffers operand pairs and issues clear/accumulate/done MAC jobs
// Optional MAC_SEQ_ABORT_EN adds an abort input that cancels the job and flushes the FIFO.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                         abort,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_a,
  input  logic [7:0]                   in_b,
  input  logic                         start,
  input  logic [LEN_W-1:0]             vec_len,
  output logic                         busy,
  output logic                         done,
  output logic                         mac_clr,
  output logic [7:0]                   mac_a,
  output logic [7:0]                   mac_b,
  output logic                         mac_acc_en,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  mac_seq_state_t state;
  mac_seq_state_t next_state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] remaining_nxt;
  logic abort_i;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic clr_nxt;
  logic acc_nxt;
  logic done_nxt;
  logic busy_nxt;
  operand_pair_t in_pair;
  operand_pair_t head;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign in_ready  = !full && !rst;
  assign push      = in_valid && in_ready && !abort_i;
  assign in_pair.a = in_a;
  assign in_pair.b = in_b;

  mac_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_i),
    .push  (push),
    .din   (in_pair),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Outputs are decided from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    next_state    = state;
    remaining_nxt = remaining;
    pop           = 1'b0;
    clr_nxt       = 1'b0;
    acc_nxt       = 1'b0;
    done_nxt      = 1'b0;
    busy_nxt      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          remaining_nxt = vec_len;
          next_state    = CLEAR;
        end
      end
      CLEAR: begin
        clr_nxt    = 1'b1;
        next_state = (remaining != '0) ? RUN : DONE;
      end
      RUN: begin
        if (!empty) begin
          pop           = 1'b1;
          acc_nxt       = 1'b1;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        done_nxt   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort_i) begin
      next_state = IDLE;
      pop        = 1'b0;
      clr_nxt    = 1'b0;
      acc_nxt    = 1'b0;
      done_nxt   = 1'b0;
      busy_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      mac_clr    <= 1'b0;
      mac_acc_en <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
    end else begin
      state      <= next_state;
      remaining  <= remaining_nxt;
      mac_clr    <= clr_nxt;
      mac_acc_en <= acc_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      if (pop) begin
        mac_a <= head.a;
        mac_b <= head.b;
      end
    end
  end

endmodule
